input_router: RTL and testbench
===============================

INPUT_ROUTER -- requirements
Module: InputRouter

Interface
REQ-001 Parameter NEURON_WIDTH, default 11, width of neuron/event ID.
REQ-002 Parameter SYN_ADDR_WIDTH, default 16, width of synapse-memory address and synapse count.
REQ-003 Parameter WEIGHT_WIDTH, default 16, width of a synaptic weight.
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-006 Initialize  in  1  synchronous clear of internal registers, honoured only in IDLE.
REQ-007 RouteEnable  in  1  request to route one event; sampled only in IDLE.
REQ-008 InputSelect  in  1  queue select: 0 = Input queue, 1 = Aux queue; sampled with RouteEnable.
REQ-009 IsInputQueueEmpty / IsAuxQueueEmpty  in  1 each  queue empty flags.
REQ-010 InputEventID / AuxEventID  in  NEURON_WIDTH each  head-of-queue source neuron ID.
REQ-011 InputDequeue / AuxDequeue  out  1 each  one-cycle pop strobe.
REQ-012 PtrRdEn out 1, PtrAddress out NEURON_WIDTH, PtrData in 2*SYN_ADDR_WIDTH ({Start, Count}); pointer-table read port.
REQ-013 SynRdEn out 1, SynAddress out SYN_ADDR_WIDTH, SynData in NEURON_WIDTH+WEIGHT_WIDTH ({Target, Weight}); synapse-memory read port.
REQ-014 AccumValid out 1, AccumReady in 1, AccumTarget out NEURON_WIDTH, AccumWeight out WEIGHT_WIDTH; valid/ready channel to neuron unit.
REQ-015 RoutingComplete  out  1  one-cycle pulse at end of each accepted route.

Function
REQ-016 States SHALL be IDLE, PTR_RD, PTR_WAIT, SYN_RD, SYN_WAIT, ISSUE, DONE.
REQ-017 IDLE, RouteEnable=1, selected queue non-empty: latch selected ID and InputSelect, go PTR_RD.
REQ-018 IDLE, RouteEnable=1, selected queue empty: no dequeue, no memory read, go DONE.
REQ-019 PTR_RD: PtrRdEn=1, PtrAddress=latched ID, selected Dequeue=1 for this single cycle only; go PTR_WAIT.
REQ-020 Memory read latency SHALL be exactly 1 cycle; data sampled in the *_WAIT state.
REQ-021 PTR_WAIT: capture Start->address register, Count->remaining register; Count=0 -> DONE, else SYN_RD.
REQ-022 SYN_RD: SynRdEn=1, SynAddress=address register; go SYN_WAIT.
REQ-023 SYN_WAIT: register SynData onto AccumTarget/AccumWeight; go ISSUE.
REQ-024 ISSUE: AccumValid=1, Target/Weight held stable until AccumValid&&AccumReady.
REQ-025 On handshake: remaining=1 -> DONE; else address+1 (modulo 2^SYN_ADDR_WIDTH), remaining-1, go SYN_RD.
REQ-026 AccumReady low SHALL stall in ISSUE indefinitely with no other output change.
REQ-027 DONE: RoutingComplete=1 for one cycle; go IDLE.
REQ-028 RouteEnable, InputSelect, queue flags ignored outside IDLE; route always runs to completion.
REQ-029 Minimum latency RouteEnable-to-RoutingComplete: empty queue 2 cycles; Count=0 4 cycles; N synapses, Ready always high, 3+3N+1 cycles.
REQ-030 Initialize and RouteEnable both high in IDLE: Initialize wins, no route starts.
REQ-031 Count SHALL be treated unsigned; Count=2^SYN_ADDR_WIDTH-1 legal.

Reset
REQ-032 Reset low: state=IDLE; all strobes (Dequeues, PtrRdEn, SynRdEn, AccumValid, RoutingComplete)=0; address, data, ID, remaining registers=0.
REQ-033 Reset mid-route SHALL abort without RoutingComplete; no further Dequeue after release.

Structure
REQ-034 Shared package SHALL hold default widths (NEURON_WIDTH, SYN_ADDR_WIDTH, WEIGHT_WIDTH, BT_WIDTH=36) and router state encoding.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Input queue ID=5, PtrData={100,3}, Ready=1 -> InputDequeue once, SynAddress 100,101,102, three Accum handshakes, RoutingComplete at cycle 13.
REQ-037 InputSelect=1, Aux ID=7, Count=0 -> AuxDequeue once, no SynRdEn, RoutingComplete 4 cycles after start; InputDequeue never.
REQ-038 RouteEnable with selected queue empty -> no Dequeue, no PtrRdEn, RoutingComplete 2 cycles later.
REQ-039 Start=0xFFFF, Count=2, Ready held low 5 cycles on first issue -> AccumValid held, values stable; SynAddress 0xFFFF then 0x0000.
REQ-040 Reset asserted in ISSUE -> all outputs 0 same cycle, no RoutingComplete; next route behaves normally.
REQ-041 Back-to-back RouteEnable held high, two events -> two distinct Dequeues, two RoutingComplete pulses, one IDLE cycle between routes.

Source files
------------

// File: rtl/input_router_pkg.sv
// Shared widths and router state encoding for the spike input router.
package input_router_pkg;

  localparam int unsigned NEURON_WIDTH   = 11;
  localparam int unsigned SYN_ADDR_WIDTH = 16;
  localparam int unsigned WEIGHT_WIDTH   = 16;
  localparam int unsigned BT_WIDTH       = 36;

  typedef logic [2:0] router_state_t;

  localparam router_state_t StIdle    = 3'd0;
  localparam router_state_t StPtrRd   = 3'd1;
  localparam router_state_t StPtrWait = 3'd2;
  localparam router_state_t StSynRd   = 3'd3;
  localparam router_state_t StSynWait = 3'd4;
  localparam router_state_t StIssue   = 3'd5;
  localparam router_state_t StDone    = 3'd6;

endpackage

// File: rtl/input_router.sv
// Routes one queued spike event: fetches its synapse range from the pointer table,
// then streams each {target, weight} synapse to the neuron unit over valid/ready.
module input_router #(
  parameter int unsigned NEURON_WIDTH   = input_router_pkg::NEURON_WIDTH,
  parameter int unsigned SYN_ADDR_WIDTH = input_router_pkg::SYN_ADDR_WIDTH,
  parameter int unsigned WEIGHT_WIDTH   = input_router_pkg::WEIGHT_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               initialize_i,
  input  logic                               route_enable_i,
  input  logic                               input_select_i,
  input  logic                               input_queue_empty_i,
  input  logic                               aux_queue_empty_i,
  input  logic [NEURON_WIDTH-1:0]            input_event_id_i,
  input  logic [NEURON_WIDTH-1:0]            aux_event_id_i,
  output logic                               input_dequeue_o,
  output logic                               aux_dequeue_o,
  output logic                               ptr_rd_en_o,
  output logic [NEURON_WIDTH-1:0]            ptr_address_o,
  input  logic [2*SYN_ADDR_WIDTH-1:0]        ptr_data_i,
  output logic                               syn_rd_en_o,
  output logic [SYN_ADDR_WIDTH-1:0]          syn_address_o,
  input  logic [NEURON_WIDTH+WEIGHT_WIDTH-1:0] syn_data_i,
  output logic                               accum_valid_o,
  input  logic                               accum_ready_i,
  output logic [NEURON_WIDTH-1:0]            accum_target_o,
  output logic [WEIGHT_WIDTH-1:0]            accum_weight_o,
  output logic                               routing_complete_o
);
  import input_router_pkg::*;

  localparam int unsigned PtrWidth = 2 * SYN_ADDR_WIDTH;

  router_state_t             state_q, state_d;
  logic                      sel_q, sel_d;
  logic [NEURON_WIDTH-1:0]   id_q, id_d;
  logic [SYN_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SYN_ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [NEURON_WIDTH-1:0]   target_q, target_d;
  logic [WEIGHT_WIDTH-1:0]   weight_q, weight_d;

  logic [SYN_ADDR_WIDTH-1:0] ptr_start;
  logic [SYN_ADDR_WIDTH-1:0] ptr_count;
  logic                      sel_empty;

  assign ptr_start = ptr_data_i[PtrWidth-1:SYN_ADDR_WIDTH];
  assign ptr_count = ptr_data_i[SYN_ADDR_WIDTH-1:0];
  assign sel_empty = input_select_i ? aux_queue_empty_i : input_queue_empty_i;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    id_d        = id_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    weight_d    = weight_q;
    unique case (state_q)
      StIdle: begin
        // Initialize takes priority over a simultaneous route request.
        if (initialize_i) begin
          sel_d       = 1'b0;
          id_d        = '0;
          addr_d      = '0;
          remaining_d = '0;
          target_d    = '0;
          weight_d    = '0;
        end else if (route_enable_i) begin
          if (sel_empty) begin
            state_d = StDone;
          end else begin
            sel_d   = input_select_i;
            id_d    = input_select_i ? aux_event_id_i : input_event_id_i;
            state_d = StPtrRd;
          end
        end
      end
      StPtrRd: state_d = StPtrWait;
      StPtrWait: begin
        addr_d      = ptr_start;
        remaining_d = ptr_count;
        state_d     = (ptr_count == '0) ? StDone : StSynRd;
      end
      StSynRd: state_d = StSynWait;
      StSynWait: begin
        {target_d, weight_d} = syn_data_i;
        state_d              = StIssue;
      end
      StIssue: begin
        if (accum_ready_i) begin
          if (remaining_q == SYN_ADDR_WIDTH'(1)) begin
            state_d = StDone;
          end else begin
            // Synapse address wraps naturally at the top of memory.
            addr_d      = addr_q + SYN_ADDR_WIDTH'(1);
            remaining_d = remaining_q - SYN_ADDR_WIDTH'(1);
            state_d     = StSynRd;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      target_q    <= '0;
      weight_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      target_q    <= target_d;
      weight_q    <= weight_d;
    end
  end

  assign ptr_rd_en_o        = (state_q == StPtrRd);
  assign input_dequeue_o    = (state_q == StPtrRd) && !sel_q;
  assign aux_dequeue_o      = (state_q == StPtrRd) && sel_q;
  assign ptr_address_o      = id_q;
  assign syn_rd_en_o        = (state_q == StSynRd);
  assign syn_address_o      = addr_q;
  assign accum_valid_o      = (state_q == StIssue);
  assign accum_target_o     = target_q;
  assign accum_weight_o     = weight_q;
  assign routing_complete_o = (state_q == StDone);

endmodule

// File: tb/tb_input_router.sv
// Self-checking bench for input_router: behavioural 1-cycle memories, a scoreboard of
// expected synapse words, and a negedge monitor that counts strobes and checks handshakes.
module tb_input_router;

  localparam int unsigned NW = 11;
  localparam int unsigned SW = 16;
  localparam int unsigned WW = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            initialize_i = 1'b0;
  logic            route_enable_i = 1'b0;
  logic            input_select_i = 1'b0;
  logic            input_queue_empty_i = 1'b1;
  logic            aux_queue_empty_i = 1'b1;
  logic [NW-1:0]   input_event_id_i = '0;
  logic [NW-1:0]   aux_event_id_i = '0;
  logic            input_dequeue_o, aux_dequeue_o;
  logic            ptr_rd_en_o;
  logic [NW-1:0]   ptr_address_o;
  logic [2*SW-1:0] ptr_data_i = '0;
  logic            syn_rd_en_o;
  logic [SW-1:0]   syn_address_o;
  logic [NW+WW-1:0] syn_data_i = '0;
  logic            accum_valid_o;
  logic            accum_ready_i = 1'b1;
  logic [NW-1:0]   accum_target_o;
  logic [WW-1:0]   accum_weight_o;
  logic            routing_complete_o;

  input_router #(
    .NEURON_WIDTH  (NW),
    .SYN_ADDR_WIDTH(SW),
    .WEIGHT_WIDTH  (WW)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .initialize_i       (initialize_i),
    .route_enable_i     (route_enable_i),
    .input_select_i     (input_select_i),
    .input_queue_empty_i(input_queue_empty_i),
    .aux_queue_empty_i  (aux_queue_empty_i),
    .input_event_id_i   (input_event_id_i),
    .aux_event_id_i     (aux_event_id_i),
    .input_dequeue_o    (input_dequeue_o),
    .aux_dequeue_o      (aux_dequeue_o),
    .ptr_rd_en_o        (ptr_rd_en_o),
    .ptr_address_o      (ptr_address_o),
    .ptr_data_i         (ptr_data_i),
    .syn_rd_en_o        (syn_rd_en_o),
    .syn_address_o      (syn_address_o),
    .syn_data_i         (syn_data_i),
    .accum_valid_o      (accum_valid_o),
    .accum_ready_i      (accum_ready_i),
    .accum_target_o     (accum_target_o),
    .accum_weight_o     (accum_weight_o),
    .routing_complete_o (routing_complete_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int nassert = 0;
  int nfail = 0;

  // Synapse memory contents are a fixed function of address.
  function automatic logic [NW+WW-1:0] syn_word(input logic [SW-1:0] a);
    logic [NW-1:0] t;
    t = a[NW-1:0] ^ 11'h2A5;
    return {t, a ^ 16'hBEEF};
  endfunction

  logic [2*SW-1:0] ptr_mem [2048];
  always @(posedge clk_i) begin
    if (ptr_rd_en_o) ptr_data_i <= ptr_mem[ptr_address_o];
    if (syn_rd_en_o) syn_data_i <= syn_word(syn_address_o);
  end

  logic [NW+WW-1:0] exp_q[$];
  logic [NW+WW-1:0] mon_exp;
  logic [SW-1:0]    syn_addr_q[$];
  int               deq_cyc_q[$];
  int               comp_cyc_q[$];
  int n_in_deq = 0, n_aux_deq = 0, n_ptr_rd = 0, n_syn_rd = 0, n_comp = 0, n_hs = 0;

  always @(negedge clk_i) begin
    if (input_dequeue_o) begin n_in_deq++; deq_cyc_q.push_back(cyc); end
    if (aux_dequeue_o) begin n_aux_deq++; deq_cyc_q.push_back(cyc); end
    if (ptr_rd_en_o) n_ptr_rd++;
    if (syn_rd_en_o) begin n_syn_rd++; syn_addr_q.push_back(syn_address_o); end
    if (routing_complete_o) begin n_comp++; comp_cyc_q.push_back(cyc); end
    if (accum_valid_o && accum_ready_i) begin
      n_hs++;
      nassert++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL accum_unexpected: got %h, required no transfer",
                 {accum_target_o, accum_weight_o});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({accum_target_o, accum_weight_o} !== mon_exp) begin
          nfail++;
          $display("FAIL accum_data: got %h, required %h",
                   {accum_target_o, accum_weight_o}, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clr();
    n_in_deq = 0; n_aux_deq = 0; n_ptr_rd = 0; n_syn_rd = 0; n_comp = 0; n_hs = 0;
    deq_cyc_q.delete(); comp_cyc_q.delete(); syn_addr_q.delete();
  endtask

  // Issue a one-cycle request; returns the cycle in which it is sampled.
  task automatic start_route(output int start);
    route_enable_i = 1'b1;
    start = cyc;
    tick();
    route_enable_i = 1'b0;
  endtask

  task automatic wait_comp(input int n);
    int b;
    b = 0;
    while (n_comp < n && b < 200) begin tick(); b++; end
    tick();
  endtask

  task automatic test_reset();
    #1;
    nassert++;
    if ({input_dequeue_o, aux_dequeue_o, ptr_rd_en_o, syn_rd_en_o, accum_valid_o,
         routing_complete_o} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_strobes: got %b, required 000000",
               {input_dequeue_o, aux_dequeue_o, ptr_rd_en_o, syn_rd_en_o, accum_valid_o,
                routing_complete_o});
    end
    nassert++;
    if ({ptr_address_o, syn_address_o, accum_target_o, accum_weight_o} !== '0) begin
      nfail++;
      $display("FAIL reset_regs: got %h, required 0",
               {ptr_address_o, syn_address_o, accum_target_o, accum_weight_o});
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_input_route();
    int st;
    clr();
    ptr_mem[5] = {16'd100, 16'd3};
    for (int i = 0; i < 3; i++) exp_q.push_back(syn_word(SW'(100 + i)));
    input_select_i = 1'b0; input_queue_empty_i = 1'b0; input_event_id_i = 11'd5;
    accum_ready_i = 1'b1;
    start_route(st);
    wait_comp(1);
    input_queue_empty_i = 1'b1;
    nassert++;
    if (n_in_deq != 1 || n_aux_deq != 0) begin
      nfail++; $display("FAIL route_dequeue: got in=%0d aux=%0d, required 1/0", n_in_deq, n_aux_deq);
    end
    nassert++;
    if (syn_addr_q.size() != 3 || syn_addr_q[0] !== 16'd100 || syn_addr_q[1] !== 16'd101 ||
        syn_addr_q[2] !== 16'd102) begin
      nfail++; $display("FAIL route_syn_addr: got %p, required 100,101,102", syn_addr_q);
    end
    nassert++;
    if (n_hs != 3 || exp_q.size() != 0) begin
      nfail++; $display("FAIL route_handshakes: got %0d, required 3", n_hs);
    end
    // Request cycle counts as cycle 1, so a 13-cycle route completes 12 cycles later.
    nassert++;
    if (n_comp != 1 || comp_cyc_q.size() == 0 || comp_cyc_q[0] - st != 12) begin
      nfail++; $display("FAIL route_latency: got n=%0d, required 1 pulse 12 cycles after request", n_comp);
    end
  endtask

  task automatic test_aux_zero_count();
    int st;
    clr();
    ptr_mem[7] = {16'd200, 16'd0};
    input_select_i = 1'b1; aux_queue_empty_i = 1'b0; aux_event_id_i = 11'd7;
    input_queue_empty_i = 1'b0; input_event_id_i = 11'd1;
    start_route(st);
    wait_comp(1);
    aux_queue_empty_i = 1'b1; input_queue_empty_i = 1'b1;
    nassert++;
    if (n_aux_deq != 1 || n_in_deq != 0) begin
      nfail++; $display("FAIL aux_dequeue: got aux=%0d in=%0d, required 1/0", n_aux_deq, n_in_deq);
    end
    nassert++;
    if (n_syn_rd != 0 || n_hs != 0) begin
      nfail++; $display("FAIL aux_no_syn: got syn_rd=%0d hs=%0d, required 0/0", n_syn_rd, n_hs);
    end
    nassert++;
    if (n_comp != 1 || comp_cyc_q.size() == 0 || comp_cyc_q[0] - st != 3) begin
      nfail++; $display("FAIL aux_latency: got n=%0d, required 1 pulse 3 cycles after request", n_comp);
    end
  endtask

  task automatic test_empty_queue();
    int st;
    clr();
    input_select_i = 1'b0; input_queue_empty_i = 1'b1; aux_queue_empty_i = 1'b0;
    start_route(st);
    wait_comp(1);
    aux_queue_empty_i = 1'b1;
    nassert++;
    if (n_in_deq != 0 || n_aux_deq != 0 || n_ptr_rd != 0) begin
      nfail++; $display("FAIL empty_no_read: got deq=%0d/%0d ptr_rd=%0d, required 0", n_in_deq, n_aux_deq, n_ptr_rd);
    end
    nassert++;
    if (n_comp != 1 || comp_cyc_q.size() == 0 || comp_cyc_q[0] - st != 1) begin
      nfail++; $display("FAIL empty_latency: got n=%0d, required 1 pulse 1 cycle after request", n_comp);
    end
  endtask

  task automatic test_wrap_stall();
    int st, b;
    logic [NW-1:0] t0;
    logic [WW-1:0] w0;
    clr();
    ptr_mem[9] = {16'hFFFF, 16'd2};
    exp_q.push_back(syn_word(16'hFFFF));
    exp_q.push_back(syn_word(16'h0000));
    input_select_i = 1'b0; input_queue_empty_i = 1'b0; input_event_id_i = 11'd9;
    accum_ready_i = 1'b0;
    start_route(st);
    input_queue_empty_i = 1'b1;
    b = 0;
    while (!accum_valid_o && b < 50) begin tick(); b++; end
    t0 = accum_target_o; w0 = accum_weight_o;
    nassert++;
    if ({t0, w0} !== syn_word(16'hFFFF)) begin
      nfail++; $display("FAIL stall_first_word: got %h, required %h", {t0, w0}, syn_word(16'hFFFF));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      nassert++;
      if (!accum_valid_o || accum_target_o !== t0 || accum_weight_o !== w0 || syn_rd_en_o) begin
        nfail++; $display("FAIL stall_hold: got valid=%b data=%h, required 1 %h",
                          accum_valid_o, {accum_target_o, accum_weight_o}, {t0, w0});
      end
    end
    accum_ready_i = 1'b1;
    wait_comp(1);
    nassert++;
    if (syn_addr_q.size() != 2 || syn_addr_q[0] !== 16'hFFFF || syn_addr_q[1] !== 16'h0000) begin
      nfail++; $display("FAIL wrap_addr: got %p, required ffff,0000", syn_addr_q);
    end
    nassert++;
    if (n_comp != 1 || comp_cyc_q.size() == 0 || comp_cyc_q[0] - st != 14 || exp_q.size() != 0) begin
      nfail++; $display("FAIL wrap_latency: got n=%0d, required 1 pulse 14 cycles after request", n_comp);
    end
  endtask

  task automatic test_initialize();
    clr();
    input_select_i = 1'b0; input_queue_empty_i = 1'b0; input_event_id_i = 11'd13;
    initialize_i = 1'b1; route_enable_i = 1'b1;
    tick();
    initialize_i = 1'b0; route_enable_i = 1'b0; input_queue_empty_i = 1'b1;
    repeat (4) tick();
    nassert++;
    if (n_ptr_rd != 0 || n_comp != 0 || n_in_deq != 0) begin
      nfail++; $display("FAIL init_no_route: got ptr_rd=%0d comp=%0d, required 0/0", n_ptr_rd, n_comp);
    end
    nassert++;
    if (ptr_address_o !== '0 || accum_target_o !== '0 || accum_weight_o !== '0) begin
      nfail++; $display("FAIL init_clear: got %h, required 0",
                        {ptr_address_o, accum_target_o, accum_weight_o});
    end
  endtask

  task automatic test_reset_mid_route();
    int st, b;
    clr();
    ptr_mem[11] = {16'd500, 16'd4};
    ptr_mem[12] = {16'd600, 16'd1};
    input_select_i = 1'b0; input_queue_empty_i = 1'b0; input_event_id_i = 11'd11;
    accum_ready_i = 1'b0;
    start_route(st);
    input_queue_empty_i = 1'b1;
    b = 0;
    while (!accum_valid_o && b < 50) begin tick(); b++; end
    rst_ni = 1'b0;
    #1;
    nassert++;
    if ({input_dequeue_o, aux_dequeue_o, ptr_rd_en_o, syn_rd_en_o, accum_valid_o,
         routing_complete_o} !== 6'b0 || {accum_target_o, accum_weight_o, syn_address_o} !== '0) begin
      nfail++; $display("FAIL midreset_outputs: got valid=%b data=%h, required all 0",
                        accum_valid_o, {accum_target_o, accum_weight_o, syn_address_o});
    end
    tick();
    rst_ni = 1'b1;
    accum_ready_i = 1'b1;
    exp_q.delete();
    repeat (8) tick();
    nassert++;
    if (n_comp != 0 || n_in_deq != 1) begin
      nfail++; $display("FAIL midreset_abort: got comp=%0d deq=%0d, required 0/1", n_comp, n_in_deq);
    end
    clr();
    exp_q.push_back(syn_word(16'd600));
    input_queue_empty_i = 1'b0; input_event_id_i = 11'd12;
    start_route(st);
    input_queue_empty_i = 1'b1;
    wait_comp(1);
    nassert++;
    if (n_comp != 1 || n_in_deq != 1 || n_hs != 1 || comp_cyc_q.size() == 0 ||
        comp_cyc_q[0] - st != 6) begin
      nfail++; $display("FAIL midreset_recover: got comp=%0d deq=%0d hs=%0d, required 1/1/1",
                        n_comp, n_in_deq, n_hs);
    end
  endtask

  task automatic test_back_to_back();
    int deqs, b;
    clr();
    ptr_mem[3] = {16'd300, 16'd1};
    ptr_mem[4] = {16'd400, 16'd2};
    exp_q.push_back(syn_word(16'd300));
    exp_q.push_back(syn_word(16'd400));
    exp_q.push_back(syn_word(16'd401));
    input_select_i = 1'b0; input_queue_empty_i = 1'b0; input_event_id_i = 11'd3;
    route_enable_i = 1'b1;
    deqs = 0; b = 0;
    while (deqs < 2 && b < 100) begin
      tick(); b++;
      if (input_dequeue_o) begin
        deqs++;
        if (deqs == 1) input_event_id_i = 11'd4;
        else begin route_enable_i = 1'b0; input_queue_empty_i = 1'b1; end
      end
    end
    route_enable_i = 1'b0; input_queue_empty_i = 1'b1;
    wait_comp(2);
    nassert++;
    if (n_in_deq != 2 || n_comp != 2) begin
      nfail++; $display("FAIL b2b_counts: got deq=%0d comp=%0d, required 2/2", n_in_deq, n_comp);
    end
    nassert++;
    if (comp_cyc_q.size() != 2 || deq_cyc_q.size() != 2 ||
        deq_cyc_q[1] - comp_cyc_q[0] != 2 || comp_cyc_q[1] - comp_cyc_q[0] != 10) begin
      nfail++; $display("FAIL b2b_timing: got comp=%p deq=%p, required one idle cycle between routes",
                        comp_cyc_q, deq_cyc_q);
    end
    nassert++;
    if (syn_addr_q.size() != 3 || syn_addr_q[0] !== 16'd300 || syn_addr_q[1] !== 16'd400 ||
        syn_addr_q[2] !== 16'd401 || n_hs != 3 || exp_q.size() != 0) begin
      nfail++; $display("FAIL b2b_synapses: got %p hs=%0d, required 300,400,401 hs=3", syn_addr_q, n_hs);
    end
  endtask

  initial begin
    test_reset();
    test_input_route();
    test_aux_zero_count();
    test_empty_queue();
    test_wrap_stall();
    test_initialize();
    test_reset_mid_route();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
